// File: rtl/unmask_buf_pkg.sv
// Shared defaults and helpers for the unmasking output buffer.
package unmask_buf_pkg;

    localparam int UNMASK_K_WIDTH_DEF = 32;
    localparam int UNMASK_DEPTH_DEF   = 4;

    // Highest occupancy at which the upstream stage may still advance; one slot
    // stays free for the word already sitting in the upstream output register.
    function automatic int ena_threshold(input int depth);
        return depth - 2;
    endfunction

endpackage

// File: rtl/unmask_buf_mem.sv
// DEPTH x K_WIDTH storage: one synchronous write port, asynchronous read port, no reset.
module unmask_buf_mem
    import unmask_buf_pkg::*;
#(
    parameter int K_WIDTH = UNMASK_K_WIDTH_DEF,
    parameter int DEPTH   = UNMASK_DEPTH_DEF,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [K_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [K_WIDTH-1:0] rdata_o
);

    logic [K_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/unmask_out_buffer.sv
// In-order output FIFO behind the 3-share unmasking stage; drives its ena for backpressure.
// Optional synchronous flush input i_clr is built when UNMASK_BUF_CLR_EN is defined.
module unmask_out_buffer
    import unmask_buf_pkg::*;
#(
    parameter int K_WIDTH = UNMASK_K_WIDTH_DEF,
    parameter int DEPTH   = UNMASK_DEPTH_DEF,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [K_WIDTH-1:0] i_z,
    input  logic               i_vld,
    output logic               o_ena,
    output logic [K_WIDTH-1:0] o_data,
    output logic               o_valid,
    input  logic               i_ready,
`ifdef UNMASK_BUF_CLR_EN
    input  logic               i_clr,
`endif
    output logic [AW:0]        o_count
);

    localparam logic [AW:0] ENA_THR = (AW+1)'(ena_threshold(DEPTH));

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               ena_q;
    logic               flush;
    logic               cap;
    logic               pop;
    logic [K_WIDTH-1:0] rd_data;

`ifdef UNMASK_BUF_CLR_EN
    assign flush = i_clr;
`else
    assign flush = 1'b0;
`endif

    // ena_q gates capture so a word held upstream during a stall is taken only once.
    assign o_ena   = ~rst & ~flush & (count_q <= ENA_THR);
    assign o_valid = (count_q != '0);
    assign cap     = i_vld & ena_q & ~flush & ~rst;
    assign pop     = o_valid & i_ready & ~flush;
    assign o_data  = o_valid ? rd_data : '0;
    assign o_count = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (cap) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (cap && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !cap) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ena_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ena_q    <= o_ena;
        end
    end

    unmask_buf_mem #(
        .K_WIDTH (K_WIDTH),
        .DEPTH   (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (cap),
        .waddr_i (wr_ptr_q),
        .wdata_i (i_z),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

endmodule
